// File: rtl/multi_decode_unit.sv
// Superscalar decode stage: accepts an N-slot bundle, splits it at intra-bundle RAW hazards
// and issues each dependency-free prefix with register operands and branch targets resolved.
module multi_decode_unit #(
    parameter int N    = 2,
    parameter int XLEN = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic [N-1:0]          i_in_valid,
    input  logic [N*16-1:0]       i_instr,
    input  logic [N*XLEN-1:0]     i_pc,
    output logic                  o_in_ready,
    output logic [N*6-1:0]        o_rf_raddr,
    input  logic [N*2*XLEN-1:0]   i_rf_rdata,
    output logic [N-1:0]          o_out_valid,
    output logic [N*4-1:0]        o_opcode,
    output logic [N*3-1:0]        o_rd,
    output logic [N*3-1:0]        o_rs1,
    output logic [N*3-1:0]        o_rs2,
    output logic [N*XLEN-1:0]     o_imm,
    output logic [N*XLEN-1:0]     o_op1,
    output logic [N*XLEN-1:0]     o_op2,
    output logic [N*XLEN-1:0]     o_branch_target_out
);

    localparam logic [3:0] OPC_BRANCH = 4'b1100;

    typedef enum logic {RUN, SPLIT} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [N*16-1:0]     r_buf_instr;
    logic [N*XLEN-1:0]   r_buf_pc;
    logic [N-1:0]        r_pend;

    logic [N*16-1:0]     w_src_instr;
    logic [N*XLEN-1:0]   w_src_pc;
    logic [N-1:0]        w_eff_valid;
    logic [N-1:0]        w_pend;
    logic [N-1:0]        w_issue;
    logic [N-1:0]        w_first;
    logic [N-1:0]        w_remain;
    logic                w_load;
    logic                w_accept;

    logic [3:0]          w_opc   [N];
    logic                w_iflag [N];
    logic [2:0]          w_rd    [N];
    logic [2:0]          w_rs1   [N];
    logic [2:0]          w_rs2   [N];
    logic [XLEN-1:0]     w_imm   [N];
    logic [XLEN-1:0]     w_op1   [N];
    logic [XLEN-1:0]     w_op2   [N];
    logic [XLEN-1:0]     w_tgt   [N];

    logic [N-1:0]        w_lane_valid;
    logic [N*4-1:0]      w_lane_opcode;
    logic [N*3-1:0]      w_lane_rd;
    logic [N*3-1:0]      w_lane_rs1;
    logic [N*3-1:0]      w_lane_rs2;
    logic [N*XLEN-1:0]   w_lane_imm;
    logic [N*XLEN-1:0]   w_lane_op1;
    logic [N*XLEN-1:0]   w_lane_op2;
    logic [N*XLEN-1:0]   w_lane_tgt;

    // A gap in in_valid kills every younger slot.
    always_comb begin
        logic run;
        run         = 1'b1;
        w_eff_valid = '0;
        for (int k = 0; k < N; k++) begin
            run            = run & i_in_valid[k];
            w_eff_valid[k] = run;
        end
    end

    always_comb begin
        if (r_state == SPLIT) begin
            w_src_instr = r_buf_instr;
            w_src_pc    = r_buf_pc;
            w_pend      = r_pend;
        end else begin
            w_src_instr = i_instr;
            w_src_pc    = i_pc;
            w_pend      = w_eff_valid;
        end
    end

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : g_slot
            assign w_opc[g]   = w_src_instr[16*g+12 +: 4];
            assign w_iflag[g] = w_src_instr[16*g+11];
            assign w_rd[g]    = w_src_instr[16*g+8 +: 3];
            assign w_rs1[g]   = w_src_instr[16*g+5 +: 3];
            assign w_rs2[g]   = w_src_instr[16*g+2 +: 3];
            assign w_imm[g]   = {{(XLEN-5){w_src_instr[16*g+4]}}, w_src_instr[16*g +: 5]};
            assign w_op1[g]   = i_rf_rdata[2*XLEN*g +: XLEN];
            assign w_op2[g]   = w_iflag[g] ? w_imm[g] : i_rf_rdata[2*XLEN*g+XLEN +: XLEN];
            assign w_tgt[g]   = w_src_pc[XLEN*g +: XLEN] + w_imm[g];
            assign o_rf_raddr[6*g +: 6] = {w_rs2[g], w_rs1[g]};
        end
    endgenerate

    // Issue pending slots in age order until the first one that reads a register written earlier in this issue group.
    always_comb begin
        logic [N-1:0] issue;
        logic         blocked;
        logic         dep;
        issue   = '0;
        blocked = 1'b0;
        for (int j = 0; j < N; j++) begin
            dep = 1'b0;
            for (int i = 0; i < j; i++) begin
                if (issue[i] && (w_opc[i] != OPC_BRANCH) &&
                    ((w_rd[i] == w_rs1[j]) || (!w_iflag[j] && (w_rd[i] == w_rs2[j])))) begin
                    dep = 1'b1;
                end
            end
            if (w_pend[j] && !blocked) begin
                if (dep) begin
                    blocked = 1'b1;
                end else begin
                    issue[j] = 1'b1;
                end
            end
        end
        w_issue = issue;
    end

    always_comb begin
        w_first    = '0;
        w_first[0] = w_issue[0];
        for (int k = 1; k < N; k++) begin
            w_first[k] = w_issue[k] & ~w_issue[k-1];
        end
    end

    assign w_remain = w_pend & ~w_issue;

    // Issued slots are contiguous, so lane l carries the slot l positions after the first issued one.
    always_comb begin
        w_lane_valid  = '0;
        w_lane_opcode = '0;
        w_lane_rd     = '0;
        w_lane_rs1    = '0;
        w_lane_rs2    = '0;
        w_lane_imm    = '0;
        w_lane_op1    = '0;
        w_lane_op2    = '0;
        w_lane_tgt    = '0;
        for (int l = 0; l < N; l++) begin
            for (int k = l; k < N; k++) begin
                if (w_issue[k] && w_first[k-l]) begin
                    w_lane_valid[l]           = 1'b1;
                    w_lane_opcode[4*l +: 4]   = w_opc[k];
                    w_lane_rd[3*l +: 3]       = w_rd[k];
                    w_lane_rs1[3*l +: 3]      = w_rs1[k];
                    w_lane_rs2[3*l +: 3]      = w_rs2[k];
                    w_lane_imm[XLEN*l +: XLEN] = w_imm[k];
                    w_lane_op1[XLEN*l +: XLEN] = w_op1[k];
                    w_lane_op2[XLEN*l +: XLEN] = w_op2[k];
                    w_lane_tgt[XLEN*l +: XLEN] = w_tgt[k];
                end
            end
        end
    end

    assign o_in_ready = (r_state == RUN) && !i_stall;
    assign w_accept   = (r_state == RUN) && !i_stall && !i_flush && i_in_valid[0];
    assign w_load     = w_accept || ((r_state == SPLIT) && !i_stall && !i_flush);

    always_comb begin
        w_state_next = r_state;
        if (i_flush) begin
            w_state_next = RUN;
        end else if (w_load) begin
            w_state_next = (|w_remain) ? SPLIT : RUN;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Flush only drops valids and the pending mask; stale field values are harmless once out_valid is low.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_buf_instr         <= '0;
            r_buf_pc            <= '0;
            r_pend              <= '0;
            o_out_valid         <= '0;
            o_opcode            <= '0;
            o_rd                <= '0;
            o_rs1               <= '0;
            o_rs2               <= '0;
            o_imm               <= '0;
            o_op1               <= '0;
            o_op2               <= '0;
            o_branch_target_out <= '0;
        end else if (i_flush) begin
            o_out_valid <= '0;
            r_pend      <= '0;
        end else if (!i_stall) begin
            if (w_load) begin
                o_out_valid         <= w_lane_valid;
                o_opcode            <= w_lane_opcode;
                o_rd                <= w_lane_rd;
                o_rs1               <= w_lane_rs1;
                o_rs2               <= w_lane_rs2;
                o_imm               <= w_lane_imm;
                o_op1               <= w_lane_op1;
                o_op2               <= w_lane_op2;
                o_branch_target_out <= w_lane_tgt;
                r_pend              <= w_remain;
                if (w_accept) begin
                    r_buf_instr <= i_instr;
                    r_buf_pc    <= i_pc;
                end
            end else begin
                o_out_valid <= '0;
            end
        end
    end

endmodule
